// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam int         LANE_W     = 8;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_NONE    = 4'b0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Two-requester load/store bus plus the single-port memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int ADDR_W = 12
);
  // Index N of every packed array belongs to requester port N.
  logic [1:0]        p_req;
  logic [1:0]        p_we;
  logic [1:0][31:0]  p_addr;
  logic [1:0][1:0]   p_size;
  logic [1:0]        p_uns;
  logic [1:0][31:0]  p_wdata;
  logic [1:0]        p_gnt;
  logic [1:0]        p_err;
  logic [1:0]        p_rvalid;
  logic [1:0][31:0]  p_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output p_req, p_we, p_addr, p_size, p_uns, p_wdata, mem_rdata,
    input  p_gnt, p_err, p_rvalid, p_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  p_req, p_we, p_addr, p_size, p_uns, p_wdata, mem_rdata,
    output p_gnt, p_err, p_rvalid, p_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/dm_lane_ctrl.sv
// ============================================================================
// Module      : dm_lane_ctrl
// Description : Byte enables, alignment check and lane replication of stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic        o_misalign,
  output logic [31:0] o_wdata
);

  logic [3:0] w_be_raw;

  always_comb begin
    w_be_raw   = BE_NONE;
    o_misalign = 1'b0;
    o_wdata    = i_wdata;
    case (i_size)
      SIZE_WORD: begin
        w_be_raw   = BE_WORD;
        o_misalign = (i_addr_lo != 2'b00);
      end
      SIZE_HALF: begin
        w_be_raw   = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        o_misalign = i_addr_lo[0];
        o_wdata    = {2{i_wdata[15:0]}};
      end
      SIZE_BYTE: begin
        w_be_raw   = BE_BYTE0 << i_addr_lo;
        o_wdata    = {4{i_wdata[7:0]}};
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

  // Enables are only meaningful for a legal store; loads and errors write nothing.
  assign o_be = (i_we && !o_misalign) ? w_be_raw : BE_NONE;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin sharing of the data memory between MEM stage and loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_arbiter_if.slave   bus
);

  state_t           r_state;
  logic             r_rr_last;
  logic             r_rsp_port;
  logic [1:0]       r_rsp_off;
  logic [1:0]       r_rsp_size;
  logic             r_rsp_uns;
  logic [1:0][31:0] r_rdata;

  logic             w_idle;
  logic             w_win;
  logic             w_grant;
  logic             w_issue;
  logic             w_misalign;
  logic             w_rsp;
  logic [1:0]       w_gnt;
  logic [1:0]       w_rvalid;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;
  req_t             w_sel;
  logic             w_unused_addr;

  // Gating with reset_n keeps grants and strobes quiet while reset is held.
  assign w_idle  = reset_n && (r_state == ST_IDLE);
  assign w_grant = w_idle && (bus.p_req != 2'b00);
  assign w_rsp   = (r_state == ST_RESP);

  always_comb begin
    if (bus.p_req == 2'b11) begin
      w_win = ~r_rr_last;
    end else begin
      w_win = bus.p_req[1];
    end
  end

  assign w_sel = '{
    we:    bus.p_we[w_win],
    addr:  bus.p_addr[w_win],
    size:  bus.p_size[w_win],
    uns:   bus.p_uns[w_win],
    wdata: bus.p_wdata[w_win]
  };

  dm_lane_ctrl u_lane_ctrl (
    .i_addr_lo  (w_sel.addr[1:0]),
    .i_size     (w_sel.size),
    .i_we       (w_sel.we),
    .i_wdata    (w_sel.wdata),
    .o_be       (w_be),
    .o_misalign (w_misalign),
    .o_wdata    (w_wdata_rep)
  );

  assign w_issue = w_grant && !w_misalign;
  assign w_gnt   = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  assign bus.p_gnt     = w_gnt;
  assign bus.p_err     = w_misalign ? w_gnt : 2'b00;
  assign bus.mem_en    = w_issue;
  assign bus.mem_we    = w_issue ? w_be : BE_NONE;
  assign bus.mem_addr  = w_sel.addr[ADDR_W+1:2];
  assign bus.mem_wdata = w_wdata_rep;

  assign w_unused_addr = ^w_sel.addr[31:ADDR_W+2];

  always_comb begin
    w_byte = bus.mem_rdata[LANE_W*r_rsp_off +: LANE_W];
    w_half = r_rsp_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_rsp_size)
      SIZE_BYTE: w_ext = {{24{~r_rsp_uns & w_byte[7]}}, w_byte};
      SIZE_HALF: w_ext = {{16{~r_rsp_uns & w_half[15]}}, w_half};
      default:   w_ext = bus.mem_rdata;
    endcase
  end

  assign w_rvalid = w_rsp ? (r_rsp_port ? 2'b10 : 2'b01) : 2'b00;

  // Live extraction while valid, otherwise the last value delivered to that port.
  assign bus.p_rvalid   = w_rvalid;
  assign bus.p_rdata[0] = w_rvalid[0] ? w_ext : r_rdata[0];
  assign bus.p_rdata[1] = w_rvalid[1] ? w_ext : r_rdata[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rr_last  <= 1'b1;
      r_rsp_port <= 1'b0;
      r_rsp_off  <= 2'b00;
      r_rsp_size <= SIZE_WORD;
      r_rsp_uns  <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_rr_last <= w_win;
            if (!w_sel.we && !w_misalign) begin
              r_rsp_port <= w_win;
              r_rsp_off  <= w_sel.addr[1:0];
              r_rsp_size <= w_sel.size;
              r_rsp_uns  <= w_sel.uns;
              r_state    <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          r_rdata[r_rsp_port] <= w_ext;
          r_state             <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed and randomized self-checking bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.ADDR_W(12)) bus ();

  dmem_arbiter #(.ADDR_W(12)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference-model state
  logic        m_rr;
  logic        m_pend;
  int          m_pport;
  logic [1:0]  m_poff;
  logic [1:0]  m_psize;
  logic        m_puns;
  logic [31:0] m_last [2];

  // Held request fields per port for the random test
  logic        q_req   [2];
  logic        q_we    [2];
  logic [31:0] q_addr  [2];
  logic [1:0]  q_size  [2];
  logic        q_uns   [2];
  logic [31:0] q_wdata [2];

  function automatic logic [31:0] f_ext(input logic [31:0] d, input logic [1:0] off,
                                        input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    logic [31:0] r;
    if (sz == 2'b10) begin
      s = (d >> (8 * off)) & 32'h0000_00FF;
      r = (!uns && s[7]) ? (s | 32'hFFFF_FF00) : s;
    end else if (sz == 2'b01) begin
      s = (d >> (16 * off[1])) & 32'h0000_FFFF;
      r = (!uns && s[15]) ? (s | 32'hFFFF_0000) : s;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic f_bad(input logic [1:0] off, input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b00 && off != 2'b00) || (sz == 2'b01 && off[0]);
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] off, input logic [1:0] sz);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'hF;
      2'b01:   be = off[1] ? 4'hC : 4'h3;
      2'b10:   be = 4'(1 << off);
      default: be = 4'h0;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] f_rep(input logic [31:0] w, input logic [1:0] sz);
    logic [31:0] r;
    if (sz == 2'b10)      r = 32'(w[7:0])  * 32'h0101_0101;
    else if (sz == 2'b01) r = 32'(w[15:0]) * 32'h0001_0001;
    else                  r = w;
    return r;
  endfunction

  task automatic drive(input int p, input logic req, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    bus.p_req[p]   = req;
    bus.p_we[p]    = we;
    bus.p_addr[p]  = addr;
    bus.p_size[p]  = size;
    bus.p_uns[p]   = uns;
    bus.p_wdata[p] = wdata;
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_all();
    bus.mem_rdata = 32'h0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b0, 32'h1111_1111);
    drive(1, 1'b1, 1'b0, 32'h4, 2'b00, 1'b0, 32'h0);
    bus.mem_rdata = 32'hDEAD_BEEF;
    cyc();
    settle();
    checks++;
    if ({bus.p_gnt, bus.p_err, bus.p_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hs got %b required 000000", {bus.p_gnt, bus.p_err, bus.p_rvalid});
    end
    checks++;
    if ({bus.mem_en, bus.mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mem got %b required 00000", {bus.mem_en, bus.mem_we});
    end
    checks++;
    if (bus.p_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h required 0", bus.p_rdata);
    end
    idle_all();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_store_byte();
    do_reset();
    drive(0, 1'b1, 1'b1, 32'h0000_0006, 2'b10, 1'b0, 32'h0000_00A5);
    settle();
    checks++;
    if ({bus.p_gnt, bus.p_err} !== 4'b0100) begin
      errors++;
      $display("FAIL stb_gnt got %b required 0100", {bus.p_gnt, bus.p_err});
    end
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 4'b0100, 12'd1}) begin
      errors++;
      $display("FAIL stb_mem got en=%b we=%b addr=%0d required en=1 we=0100 addr=1",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    checks++;
    if (bus.mem_wdata !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL stb_wdata got %h required a5a5a5a5", bus.mem_wdata);
    end
    cyc();
    idle_all();
    settle();
    checks++;
    if ({bus.p_rvalid, bus.mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL stb_norv got %b required 000", {bus.p_rvalid, bus.mem_en});
    end
    cyc();
  endtask

  task automatic test_load_half();
    logic [31:0] exp;
    for (int u = 0; u < 2; u++) begin
      exp = (u == 0) ? 32'hFFFF_8123 : 32'h0000_8123;
      drive(1, 1'b1, 1'b0, 32'h0000_000A, 2'b01, u[0], 32'h0);
      settle();
      checks++;
      if ({bus.p_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 1'b1, 4'b0, 12'd2}) begin
        errors++;
        $display("FAIL ldh_issue uns=%0d got gnt=%b en=%b we=%b addr=%0d required 10 1 0000 2",
                 u, bus.p_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      cyc();
      idle_all();
      bus.mem_rdata = 32'h8123_0000;
      settle();
      checks++;
      if ({bus.p_rvalid, bus.p_gnt} !== 4'b1000 || bus.p_rdata[1] !== exp) begin
        errors++;
        $display("FAIL ldh_resp uns=%0d got rv=%b gnt=%b rdata=%h required rv=10 gnt=00 rdata=%h",
                 u, bus.p_rvalid, bus.p_gnt, bus.p_rdata[1], exp);
      end
      cyc();
      bus.mem_rdata = $urandom;
      settle();
      checks++;
      if (bus.p_rvalid !== 2'b00 || bus.p_rdata[1] !== exp) begin
        errors++;
        $display("FAIL ldh_hold uns=%0d got rv=%b rdata=%h required rv=00 rdata=%h",
                 u, bus.p_rvalid, bus.p_rdata[1], exp);
      end
      cyc();
    end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, 1'b1, 32'h40, 2'b00, 1'b0, 32'h1000_0000 + i);
      drive(1, 1'b1, 1'b1, 32'h80, 2'b00, 1'b0, 32'h2000_0000 + i);
      settle();
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 32'h1000_0000 + i : 32'h2000_0000 + i;
      checks++;
      if ({bus.p_gnt, bus.mem_en, bus.mem_we} !== {exp_g, 5'b1_1111} || bus.mem_wdata !== exp_d) begin
        errors++;
        $display("FAIL alt_%0d got gnt=%b en=%b we=%b wdata=%h required gnt=%b en=1 we=1111 wdata=%h",
                 i, bus.p_gnt, bus.mem_en, bus.mem_we, bus.mem_wdata, exp_g, exp_d);
      end
      cyc();
    end
    idle_all();
    cyc();
  endtask

  task automatic test_misalign();
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h0000_0201, 2'b01, 1'b0, 32'h0000_BEEF);
    settle();
    checks++;
    if ({bus.p_gnt, bus.p_err, bus.mem_en, bus.mem_we} !== {2'b01, 2'b01, 5'b0}) begin
      errors++;
      $display("FAIL mis_p0 got gnt=%b err=%b en=%b we=%b required 01 01 0 0000",
               bus.p_gnt, bus.p_err, bus.mem_en, bus.mem_we);
    end
    cyc();
    drive(0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    settle();
    checks++;
    if ({bus.p_gnt, bus.p_err, bus.mem_en, bus.mem_we, bus.p_rvalid} !== {2'b10, 2'b10, 5'b0, 2'b00}) begin
      errors++;
      $display("FAIL mis_p1 got gnt=%b err=%b en=%b we=%b rv=%b required 10 10 0 0000 00",
               bus.p_gnt, bus.p_err, bus.mem_en, bus.mem_we, bus.p_rvalid);
    end
    cyc();
    drive(1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h0000_0200, 2'b11, 1'b0, 32'h0);
    settle();
    checks++;
    if ({bus.p_gnt, bus.p_err, bus.mem_en, bus.p_rvalid} !== {2'b01, 2'b01, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL mis_ill got gnt=%b err=%b en=%b rv=%b required 01 01 0 00",
               bus.p_gnt, bus.p_err, bus.mem_en, bus.p_rvalid);
    end
    cyc();
    idle_all();
    settle();
    checks++;
    if ({bus.p_rvalid, bus.mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL mis_norv got %b required 000", {bus.p_rvalid, bus.mem_en});
    end
    cyc();
  endtask

  task automatic test_resp_block();
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0);
    settle();
    checks++;
    if ({bus.p_gnt, bus.mem_en, bus.mem_addr} !== {2'b01, 1'b1, 12'd4}) begin
      errors++;
      $display("FAIL rb_ld got gnt=%b en=%b addr=%0d required 01 1 4", bus.p_gnt, bus.mem_en, bus.mem_addr);
    end
    cyc();
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 2'b00, 1'b0, 32'h0A0A_0A0A);
    drive(1, 1'b1, 1'b1, 32'h0000_0030, 2'b00, 1'b0, 32'h0B0B_0B0B);
    bus.mem_rdata = 32'h1234_5678;
    settle();
    checks++;
    if ({bus.p_gnt, bus.mem_en, bus.p_rvalid} !== {2'b00, 1'b0, 2'b01} || bus.p_rdata[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rb_resp got gnt=%b en=%b rv=%b rdata=%h required 00 0 01 12345678",
               bus.p_gnt, bus.mem_en, bus.p_rvalid, bus.p_rdata[0]);
    end
    cyc();
    bus.mem_rdata = $urandom;
    settle();
    checks++;
    if ({bus.p_gnt, bus.mem_en} !== 3'b101 || bus.mem_wdata !== 32'h0B0B_0B0B) begin
      errors++;
      $display("FAIL rb_next got gnt=%b en=%b wdata=%h required 10 1 0b0b0b0b",
               bus.p_gnt, bus.mem_en, bus.mem_wdata);
    end
    cyc();
    idle_all();
    cyc();
  endtask

  task automatic test_reset_mid_resp();
    do_reset();
    drive(1, 1'b1, 1'b0, 32'h0000_0044, 2'b00, 1'b0, 32'h0);
    cyc();
    idle_all();
    bus.mem_rdata = 32'hCAFE_F00D;
    settle();
    checks++;
    if (bus.p_rvalid !== 2'b10) begin
      errors++;
      $display("FAIL rst_pre got rv=%b required 10", bus.p_rvalid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.p_rvalid, bus.p_gnt, bus.mem_en} !== 5'b0 || bus.p_rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid got rv=%b gnt=%b en=%b rdata=%h required 00 00 0 0",
               bus.p_rvalid, bus.p_gnt, bus.mem_en, bus.p_rdata[1]);
    end
    cyc();
    cyc();
    reset_n = 1'b1;
    settle();
    checks++;
    if (bus.p_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL rst_norv got rv=%b required 00", bus.p_rvalid);
    end
    cyc();
    drive(0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b0, 32'h1);
    drive(1, 1'b1, 1'b1, 32'h4, 2'b00, 1'b0, 32'h2);
    settle();
    checks++;
    if (bus.p_gnt !== 2'b01) begin
      errors++;
      $display("FAIL rst_first got gnt=%b required 01", bus.p_gnt);
    end
    cyc();
    idle_all();
    cyc();
  endtask

  task automatic test_random();
    logic        gl [2];
    logic [1:0]  act;
    logic        any;
    int          win;
    logic        bad;
    logic [1:0]  exp_g, exp_e, exp_rv;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] ext;
    logic [31:0] exp_rd [2];
    int          sel;
    do_reset();
    m_rr = 1'b1;
    m_pend = 1'b0;
    m_pport = 0;
    m_poff = 2'b00;
    m_psize = 2'b00;
    m_puns = 1'b0;
    m_last[0] = 32'h0;
    m_last[1] = 32'h0;
    for (int p = 0; p < 2; p++) begin
      q_req[p] = 1'b0;
      gl[p] = 1'b0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!q_req[p] || gl[p]) begin
          q_req[p]   = ($urandom_range(0, 9) < 6);
          sel        = $urandom_range(0, 9);
          q_size[p]  = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
          q_addr[p]  = $urandom & 32'h0000_3FFF;
          if ($urandom_range(0, 3) != 0) begin
            if (q_size[p] == 2'b00) q_addr[p] = q_addr[p] & ~32'h3;
            if (q_size[p] == 2'b01) q_addr[p] = q_addr[p] & ~32'h1;
          end
          q_we[p]    = $urandom_range(0, 1) == 1;
          q_uns[p]   = $urandom_range(0, 1) == 1;
          q_wdata[p] = $urandom;
        end
        drive(p, q_req[p], q_we[p], q_addr[p], q_size[p], q_uns[p], q_wdata[p]);
        gl[p] = 1'b0;
      end
      bus.mem_rdata = $urandom;
      settle();

      act    = {q_req[1], q_req[0]};
      any    = !m_pend && (act != 2'b00);
      win    = (act == 2'b11) ? (m_rr ? 0 : 1) : (act[1] ? 1 : 0);
      bad    = f_bad(q_addr[win][1:0], q_size[win]);
      exp_g  = any ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_e  = (any && bad) ? exp_g : 2'b00;
      exp_rv = m_pend ? ((m_pport == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_en = any && !bad;
      exp_we = (exp_en && q_we[win]) ? f_be(q_addr[win][1:0], q_size[win]) : 4'h0;
      ext    = f_ext(bus.mem_rdata, m_poff, m_psize, m_puns);
      for (int p = 0; p < 2; p++) begin
        exp_rd[p] = (m_pend && m_pport == p) ? ext : m_last[p];
      end

      checks++;
      if ({bus.p_gnt, bus.p_err, bus.p_rvalid} !== {exp_g, exp_e, exp_rv}) begin
        errors++;
        $display("FAIL rnd_hs cyc=%0d got gnt=%b err=%b rv=%b required gnt=%b err=%b rv=%b",
                 n, bus.p_gnt, bus.p_err, bus.p_rvalid, exp_g, exp_e, exp_rv);
      end
      checks++;
      if ({bus.mem_en, bus.mem_we} !== {exp_en, exp_we}) begin
        errors++;
        $display("FAIL rnd_mem cyc=%0d got en=%b we=%b required en=%b we=%b",
                 n, bus.mem_en, bus.mem_we, exp_en, exp_we);
      end
      if (exp_en) begin
        checks++;
        if (bus.mem_addr !== q_addr[win][13:2]) begin
          errors++;
          $display("FAIL rnd_addr cyc=%0d got %h required %h", n, bus.mem_addr, q_addr[win][13:2]);
        end
      end
      if (exp_en && q_we[win]) begin
        checks++;
        if (bus.mem_wdata !== f_rep(q_wdata[win], q_size[win])) begin
          errors++;
          $display("FAIL rnd_wdata cyc=%0d got %h required %h",
                   n, bus.mem_wdata, f_rep(q_wdata[win], q_size[win]));
        end
      end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (bus.p_rdata[p] !== exp_rd[p]) begin
          errors++;
          $display("FAIL rnd_rdata%0d cyc=%0d got %h required %h", p, n, bus.p_rdata[p], exp_rd[p]);
        end
      end

      cyc();
      if (m_pend) begin
        m_last[m_pport] = ext;
        m_pend = 1'b0;
      end else if (any) begin
        m_rr = (win == 1);
        gl[win] = 1'b1;
        if (!bad && !q_we[win]) begin
          m_pend  = 1'b1;
          m_pport = win;
          m_poff  = q_addr[win][1:0];
          m_psize = q_size[win];
          m_puns  = q_uns[win];
        end
      end
    end
    idle_all();
    cyc();
  endtask

  initial begin
    idle_all();
    bus.mem_rdata = 32'h0;
    test_reset();
    test_store_byte();
    test_load_half();
    test_alternate();
    test_misalign();
    test_resp_block();
    test_reset_mid_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
